// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional encoder and its Viterbi partner:
// FSM state encoding, default K=3 (7,5 octal) generators, the rate-2/3
// puncture pattern and the parity helper used by the branch-metric unit.
package conv_pkg;

    // Encoder FSM: information bits, then K-1 zero tail symbols.
    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } conv_state_t;

    // Largest supported constraint length; parity helper is sized to it.
    localparam int CONV_MAX_K = 9;

    // Default code: K=3, generators 7 and 5 octal.
    localparam int         CONV_DEF_K  = 3;
    localparam logic [2:0] CONV_DEF_G0 = 3'b111;
    localparam logic [2:0] CONV_DEF_G1 = 3'b101;

    // Puncture masks, bit0 = parity 0, bit1 = parity 1 (1 = transmitted).
    localparam logic [1:0] PUNCT_MASK_P0 = 2'b11;
    localparam logic [1:0] PUNCT_MASK_P1 = 2'b01;

    // One output symbol as held in the output register.
    typedef struct packed {
        logic [1:0] parities;
        logic [1:0] mask;
        logic       last;
    } conv_sym_t;

    // Parity of a window against a generator. Both operands are
    // zero-extended to CONV_MAX_K so one helper serves every K.
    function automatic logic conv_parity(input logic [CONV_MAX_K-1:0] window,
                                         input logic [CONV_MAX_K-1:0] poly);
        return ^(window & poly);
    endfunction

endpackage

// File: rtl/conv_out_reg.sv
// Single-entry valid/ready output register for encoder symbols. The producer
// may load only when slot_free, which also allows load in the same cycle the
// sink drains the current entry (full throughput with out_ready held high).
module conv_out_reg
    import conv_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  conv_sym_t  sym_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [1:0] parities,
    output logic [1:0] out_mask,
    output logic       out_last,
    output logic       slot_free
);

    assign slot_free = !out_valid || out_ready;

    // Hold the symbol while stalled; replace it on load, empty on drain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            parities  <= 2'b00;
            out_mask  <= 2'b11;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            parities  <= sym_in.parities;
            out_mask  <= sym_in.mask;
            out_last  <= sym_in.last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 convolutional encoder with zero-tail termination.
// Each frame is FRAME_LEN information symbols followed by K-1 tail symbols
// that flush the shift register back to state 0 for the Viterbi decoder.
// Optional rate-2/3 puncturing is enabled by defining CONV_ENC_PUNCTURE_EN.
module conv_encoder_framed
    import conv_pkg::*;
#(
    parameter int           K         = CONV_DEF_K,
    parameter logic [K-1:0] G0        = CONV_DEF_G0,
    parameter logic [K-1:0] G1        = CONV_DEF_G1,
    parameter int           FRAME_LEN = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic        in_bit,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  parities,
    output logic [1:0]  out_mask,
    output logic        out_last,
    output logic [15:0] frame_cnt
);

    localparam int BCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TCW = $clog2(K);

    conv_state_t          state, state_nx;
    logic [K-2:0]         sr, sr_nx;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nx;
    logic [TCW-1:0]       tail_cnt, tail_cnt_nx;
    logic [15:0]          frame_cnt_q;
    logic                 slot_free;
    logic                 fire;
    logic                 u;
    logic                 last_sym;
    logic                 frame_done;
    logic [K-1:0]         window;
    conv_sym_t            sym;

    // Window bit K-1 is the current input and bit 0 the oldest stored bit,
    // so generator bit K-1-j taps the input j symbols back. The register
    // keeps the newest past bit in sr[0], hence the reversal here.
    always_comb begin
        window      = '0;
        window[K-1] = u;
        for (int j = 1; j < K; j++) begin
            window[K-1-j] = sr[j-1];
        end
    end

    assign sym.parities[0] = conv_parity(CONV_MAX_K'(window), CONV_MAX_K'(G0));
    assign sym.parities[1] = conv_parity(CONV_MAX_K'(window), CONV_MAX_K'(G1));
    assign sym.last        = last_sym;

`ifdef CONV_ENC_PUNCTURE_EN
    logic phase;

    // Puncture phase alternates per produced symbol and restarts each frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= 1'b0;
        end else if (fire) begin
            phase <= last_sym ? 1'b0 : ~phase;
        end
    end

    assign sym.mask = phase ? PUNCT_MASK_P1 : PUNCT_MASK_P0;
`else
    assign sym.mask = PUNCT_MASK_P0;
`endif

    // Next-state logic: accept data bits, then emit K-1 zero-input tail symbols.
    always_comb begin
        state_nx    = state;
        sr_nx       = sr;
        bit_cnt_nx  = bit_cnt;
        tail_cnt_nx = tail_cnt;
        in_ready    = 1'b0;
        fire        = 1'b0;
        u           = 1'b0;
        last_sym    = 1'b0;
        frame_done  = 1'b0;
        case (state)
            DATA: begin
                in_ready = slot_free;
                u        = in_bit;
                if (in_valid && slot_free) begin
                    fire = 1'b1;
                    if (bit_cnt == BCW'(FRAME_LEN - 1)) begin
                        bit_cnt_nx = '0;
                        state_nx   = TAIL;
                    end else begin
                        bit_cnt_nx = bit_cnt + 1'b1;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    fire = 1'b1;
                    if (tail_cnt == TCW'(K - 2)) begin
                        last_sym    = 1'b1;
                        frame_done  = 1'b1;
                        tail_cnt_nx = '0;
                        state_nx    = DATA;
                    end else begin
                        tail_cnt_nx = tail_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = DATA;
        endcase
        // The final tail symbol leaves the register at zero by construction;
        // clearing explicitly keeps the next frame's start state obvious.
        if (fire) begin
            sr_nx = last_sym ? '0 : {sr[K-3:0], u};
        end
    end

    // State, shift register, counters and completed-frame count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= DATA;
            sr          <= '0;
            bit_cnt     <= '0;
            tail_cnt    <= '0;
            frame_cnt_q <= 16'd0;
        end else begin
            state    <= state_nx;
            sr       <= sr_nx;
            bit_cnt  <= bit_cnt_nx;
            tail_cnt <= tail_cnt_nx;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;

    conv_out_reg u_out_reg (
        .CLK       (CLK),
        .RST       (RST),
        .load      (fire),
        .sym_in    (sym),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .parities  (parities),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_conv_encoder_framed.sv
// Bench for conv_encoder_framed: a K=3 (7,5) instance with FRAME_LEN=4 checked
// against hand-derived vectors and a convolution reference model, plus a
// K=7 (171,133) instance checked against its generator impulse response.
module tb_conv_encoder_framed;

    localparam int         KA  = 3;
    localparam logic [2:0] GA0 = 3'b111;
    localparam logic [2:0] GA1 = 3'b101;
    localparam int         FL  = 4;
    localparam int         KB  = 7;
    localparam logic [6:0] GB0 = 7'o171;
    localparam logic [6:0] GB1 = 7'o133;
`ifdef CONV_ENC_PUNCTURE_EN
    localparam bit PUNCT = 1'b1;
`else
    localparam bit PUNCT = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] par;
        logic [1:0] mask;
        logic       last;
    } sym_t;

    typedef struct {
        logic       b   [4];
        logic [1:0] par [6];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_in_valid, a_in_bit, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [1:0]  a_par, a_mask;
    logic [15:0] a_fcnt;
    logic        b_in_valid, b_in_bit, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [1:0]  b_par, b_mask;
    logic [15:0] b_fcnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    sym_t        exp_q[$];
    sym_t        obs_q[$];
    sym_t        b_obs_q[$];
    logic [31:0] hist;
    int          acc;
    int          frames;
    int          b_acc;
    logic        hold_pend;
    sym_t        hold_sym;
    vec_t        tbl [4];

    always #5 clk = ~clk;

    conv_encoder_framed #(.K(KA), .G0(GA0), .G1(GA1), .FRAME_LEN(FL)) dut_a (
        .CLK(clk), .RST(rst), .in_valid(a_in_valid), .in_bit(a_in_bit), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .parities(a_par), .out_mask(a_mask),
        .out_last(a_out_last), .frame_cnt(a_fcnt)
    );

    conv_encoder_framed #(.K(KB), .G0(GB0), .G1(GB1), .FRAME_LEN(FL)) dut_b (
        .CLK(clk), .RST(rst), .in_valid(b_in_valid), .in_bit(b_in_bit), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .parities(b_par), .out_mask(b_mask),
        .out_last(b_out_last), .frame_cnt(b_fcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] exp_mask(input int idx);
        return (PUNCT && (idx % 2 == 1)) ? 2'b01 : 2'b11;
    endfunction

    // Reference symbol: plain convolution, parity i = XOR over j of
    // Gi[k-1-j] * x[t-j] (the input j steps back, zero before frame start).
    function automatic sym_t model_sym(input int k, input logic [8:0] g0, input logic [8:0] g1,
                                       input logic [31:0] x, input int t, input bit last);
        sym_t s;
        logic p0, p1;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int j = 0; j < k; j++) begin
            if (t - j >= 0) begin
                p0 = p0 ^ (g0[k-1-j] & x[t-j]);
                p1 = p1 ^ (g1[k-1-j] & x[t-j]);
            end
        end
        s.par  = {p1, p0};
        s.mask = exp_mask(t);
        s.last = last;
        return s;
    endfunction

    // Model for DUT A: each accepted bit yields one symbol; the frame's last
    // bit also queues the K-1 zero-input tail symbols.
    task automatic model_accept(input logic b);
        hist[acc] = b;
        exp_q.push_back(model_sym(KA, 9'(GA0), 9'(GA1), hist, acc, 1'b0));
        acc++;
        if (acc == FL) begin
            for (int t = 0; t < KA - 1; t++) begin
                exp_q.push_back(model_sym(KA, 9'(GA0), 9'(GA1), hist, FL + t, t == KA - 2));
            end
            frames++;
            acc  = 0;
            hist = '0;
        end
    endtask

    // One clock: sample at the falling edge (handshakes that complete on the
    // coming rising edge), then return 1 time unit after the rising edge.
    task automatic cycle();
        sym_t cur, e;
        @(negedge clk);
        if (!rst) begin
            cur = '{par: a_par, mask: a_mask, last: a_out_last};
            if (hold_pend) begin
                check("hold_stable", 32'({a_out_valid, cur}), 32'({1'b1, hold_sym}));
            end
            hold_pend = a_out_valid && !a_out_ready;
            hold_sym  = cur;
            if (a_out_valid && a_out_ready) begin
                obs_q.push_back(cur);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_symbol: got %0h, expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("a_symbol", 32'(cur), 32'(e));
                end
            end
            if (a_in_valid && a_in_ready) model_accept(a_in_bit);
            if (b_out_valid && b_out_ready) begin
                b_obs_q.push_back('{par: b_par, mask: b_mask, last: b_out_last});
            end
            if (b_in_valid && b_in_ready) b_acc++;
        end else begin
            hold_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Send one table frame with the sink always ready and compare the
    // captured stream against the hand-derived vector.
    task automatic run_row(input int r);
        int f0;
        obs_q.delete();
        f0 = frames;
        a_out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            a_in_valid = (frames == f0);
            a_in_bit   = tbl[r].b[acc];
            cycle();
        end
        a_in_valid = 1'b0;
        check("row_count", 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            check("row_parities", 32'(obs_q[i].par), 32'(tbl[r].par[i]));
            check("row_mask", 32'(obs_q[i].mask), 32'(exp_mask(i)));
            check("row_last", 32'(obs_q[i].last), 32'(i == 5));
        end
        check("row_frame_cnt", 32'(a_fcnt), 32'(frames[15:0]));
    endtask

    initial begin
        tbl[0].b = '{1'b1, 1'b0, 1'b1, 1'b1};
        tbl[0].par = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        tbl[1].b = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1].par = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[2].b = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2].par = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[3].b = '{1'b1, 1'b1, 1'b1, 1'b1};
        tbl[3].par = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11};

        hist = '0; acc = 0; frames = 0; b_acc = 0; hold_pend = 1'b0; hold_sym = '0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_bit = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state.
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_parities", 32'(a_par), 32'd0);
        check("rst_out_mask", 32'(a_mask), 32'd3);
        check("rst_out_last", 32'(a_out_last), 32'd0);
        check("rst_frame_cnt", 32'(a_fcnt), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);

        // K=7 impulse: symbols follow the generator bits MSB first, then zeros.
        for (int c = 0; c < 14; c++) begin
            b_in_valid = (b_acc < FL);
            b_in_bit   = (b_acc == 0);
            cycle();
        end
        b_in_valid = 1'b0;
        check("k7_count", 32'(b_obs_q.size()), 32'(FL + KB - 1));
        for (int t = 0; t < FL + KB - 1 && t < b_obs_q.size(); t++) begin
            check("k7_parities", 32'(b_obs_q[t].par),
                  (t < KB) ? 32'({GB1[KB-1-t], GB0[KB-1-t]}) : 32'd0);
            check("k7_mask", 32'(b_obs_q[t].mask), 32'(exp_mask(t)));
            check("k7_last", 32'(b_obs_q[t].last), 32'(t == FL + KB - 2));
        end
        check("k7_frame_cnt", 32'(b_fcnt), 32'd1);

        // Table vectors, one frame each, consecutive frames restart the mask.
        for (int r = 0; r < 4; r++) run_row(r);

        // Tail stall: hold out_ready low for 3 cycles on tail symbol 1.
        obs_q.delete();
        a_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            a_in_valid = 1'b1;
            a_in_bit   = tbl[0].b[acc];
            cycle();
        end
        a_in_valid = 1'b0;
        cycle();
        cycle();
        a_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        check("stall_valid_held", 32'(a_out_valid), 32'd1);
        a_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) cycle();
        check("stall_count", 32'(obs_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            check("stall_parities", 32'(obs_q[i].par), 32'(tbl[0].par[i]));
        end
        check("stall_frame_cnt", 32'(a_fcnt), 32'(frames[15:0]));

        // Back-to-back frames at full rate: 12 symbols drain in 13 cycles.
        obs_q.delete();
        begin
            int f0;
            f0 = frames;
            for (int c = 0; c < 13; c++) begin
                a_in_valid = (frames < f0 + 2);
                a_in_bit   = tbl[0].b[acc];
                cycle();
            end
        end
        a_in_valid = 1'b0;
        check("b2b_count", 32'(obs_q.size()), 32'd12);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
            check("b2b_parities", 32'(obs_q[i].par), 32'(tbl[0].par[i % 6]));
        end
        check("b2b_frame_cnt", 32'(a_fcnt), 32'(frames[15:0]));

        // Reset after two accepted bits discards the partial frame.
        a_out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            a_in_valid = 1'b1;
            a_in_bit   = 1'b1;
            cycle();
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        acc = 0; hist = '0; frames = 0; hold_pend = 1'b0;
        check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_frame_cnt", 32'(a_fcnt), 32'd0);
        run_row(0);

        // Random traffic on both sides against the reference model.
        for (int c = 0; c < 800; c++) begin
            a_in_valid  = ($urandom_range(3) != 0);
            a_in_bit    = 1'($urandom_range(1));
            a_out_ready = ($urandom_range(2) != 0);
            cycle();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 20; c++) cycle();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_frame_cnt", 32'(a_fcnt), 32'(frames[15:0]));
        check("rand_idle_valid", 32'(a_out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
